// File: rtl/snn_timestep_sequencer_pkg.sv
// snn_seq_pkg: shared state encoding, default widths and stage one-hot helper for the timestep sequencer
package snn_seq_pkg;
  localparam int TU_W_DEF = 16;
  localparam int STG_W_DEF = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2} state_t;
  function automatic logic [31:0] idx_to_onehot(input logic [31:0] idx);
    return 32'd1 << idx;
  endfunction
endpackage

// File: rtl/snn_timestep_sequencer_if.sv
// snn_timestep_sequencer_if: host/stage-engine bus of the timestep sequencer; master drives requests, slave is the sequencer
interface snn_timestep_sequencer_if
  import snn_seq_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int TU_W = TU_W_DEF,
  parameter int STG_W = STG_W_DEF
);
  logic valid_ips;
  logic start_core_img;
  logic cont_mode;
  logic [TU_W-1:0] num_timesteps;
  logic abort;
  logic [NUM_STAGES-1:0] stage_done;
  logic [NUM_STAGES-1:0] stage_start;
  logic [STG_W-1:0] stage_idx;
  logic [TU_W-1:0] TU;
  logic TU_incre;
  logic done_core_img;
  logic busy;
  logic aborted;
  logic timeout;
  modport master (
    output valid_ips, start_core_img, cont_mode, num_timesteps, abort, stage_done,
    input stage_start, stage_idx, TU, TU_incre, done_core_img, busy, aborted, timeout
  );
  modport slave (
    input valid_ips, start_core_img, cont_mode, num_timesteps, abort, stage_done,
    output stage_start, stage_idx, TU, TU_incre, done_core_img, busy, aborted, timeout
  );
endinterface

// File: rtl/snn_stage_watchdog.sv
// snn_stage_watchdog: per-stage cycle counter, reloaded on each stage start, expiring after TIMEOUT_CYCLES run cycles
module snn_stage_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic rst,
  input logic clear,
  input logic run,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clear) cnt <= CW'(1);
    else if (run && cnt != CW'(TIMEOUT_CYCLES)) cnt <= cnt + CW'(1);
  assign expire = run && cnt == CW'(TIMEOUT_CYCLES);
endmodule

// File: rtl/snn_timestep_sequencer.sv
// snn_timestep_sequencer: sequences NUM_STAGES stages per timestep over an image; SEQ_TIMEOUT_EN adds a per-stage watchdog
module snn_timestep_sequencer
  import snn_seq_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int TU_W = TU_W_DEF,
  parameter int STG_W = STG_W_DEF,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic rst,
  snn_timestep_sequencer_if.slave bus
);
  state_t st, st_n;
  logic [TU_W-1:0] lim, lim_n, tu_n;
  logic [STG_W-1:0] idx_n;
  logic [NUM_STAGES-1:0] cur, ss_n;
  logic busy_n, gate, gate_n, inc_n, done_n, ab_n, to_n, hit, last, to_exp;
  assign cur = NUM_STAGES'(idx_to_onehot(32'(bus.stage_idx)));
  assign hit = st == RUN && |(bus.stage_done & cur);
  assign last = bus.stage_idx == STG_W'(NUM_STAGES - 1);
`ifdef SEQ_TIMEOUT_EN
  snn_stage_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk(clk), .rst(rst), .clear(|ss_n), .run(st == RUN), .expire(to_exp)
  );
`else
  assign to_exp = 1'b0;
`endif
  // gate: in single-shot mode, later timesteps also need start_core_img alongside valid_ips
  always_comb begin
    st_n = st;
    lim_n = lim;
    tu_n = bus.TU;
    idx_n = bus.stage_idx;
    busy_n = bus.busy;
    gate_n = gate;
    ss_n = '0;
    inc_n = 1'b0;
    done_n = 1'b0;
    ab_n = 1'b0;
    to_n = 1'b0;
    if (st != IDLE && (bus.abort || (to_exp && !hit))) begin
      st_n = IDLE;
      tu_n = '0;
      idx_n = '0;
      busy_n = 1'b0;
      ab_n = 1'b1;
      to_n = to_exp && !hit;
    end else if (st == IDLE) begin
      if (bus.start_core_img) begin
        st_n = ARMED;
        busy_n = 1'b1;
        gate_n = 1'b0;
        idx_n = '0;
        lim_n = bus.num_timesteps == '0 ? TU_W'(1) : bus.num_timesteps;
      end
    end else if (st == ARMED) begin
      if (bus.valid_ips && (!gate || bus.start_core_img)) begin
        st_n = RUN;
        idx_n = '0;
        ss_n = NUM_STAGES'(1);
      end
    end else if (hit && !last) begin
      idx_n = bus.stage_idx + STG_W'(1);
      ss_n = NUM_STAGES'(idx_to_onehot(32'(idx_n)));
    end else if (hit) begin
      inc_n = 1'b1;
      idx_n = '0;
      done_n = bus.TU == lim - TU_W'(1);
      tu_n = done_n ? '0 : bus.TU + TU_W'(1);
      busy_n = !done_n;
      st_n = done_n ? IDLE : ARMED;
      gate_n = !bus.cont_mode;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= IDLE;
      lim <= TU_W'(1);
      gate <= 1'b0;
      bus.TU <= '0;
      bus.stage_idx <= '0;
      bus.busy <= 1'b0;
      bus.stage_start <= '0;
      bus.TU_incre <= 1'b0;
      bus.done_core_img <= 1'b0;
      bus.aborted <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      st <= st_n;
      lim <= lim_n;
      gate <= gate_n;
      bus.TU <= tu_n;
      bus.stage_idx <= idx_n;
      bus.busy <= busy_n;
      bus.stage_start <= ss_n;
      bus.TU_incre <= inc_n;
      bus.done_core_img <= done_n;
      bus.aborted <= ab_n;
      bus.timeout <= to_n;
    end
endmodule

// File: tb/tb_snn_timestep_sequencer.sv
// tb_snn_timestep_sequencer: directed self-checking bench for a 2-stage and a 4-stage sequencer
module tb_snn_timestep_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;

  snn_timestep_sequencer_if #(.NUM_STAGES(2), .TU_W(16), .STG_W(2)) i2 ();
  snn_timestep_sequencer_if #(.NUM_STAGES(4), .TU_W(16), .STG_W(2)) i4 ();
  snn_timestep_sequencer #(.NUM_STAGES(2), .TU_W(16), .STG_W(2), .TIMEOUT_CYCLES(16)) u2 (
    .clk(clk), .rst(rst), .bus(i2.slave)
  );
  snn_timestep_sequencer #(.NUM_STAGES(4), .TU_W(16), .STG_W(2), .TIMEOUT_CYCLES(16)) u4 (
    .clk(clk), .rst(rst), .bus(i4.slave)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start2(input int n, input bit cont);
    i2.num_timesteps = 16'(n);
    i2.cont_mode = cont;
    i2.start_core_img = 1'b1;
    tick();
    i2.start_core_img = 1'b0;
  endtask

  // one timestep on the 2-stage DUT: each stage_done arrives 2 cycles after its stage_start
  task automatic step2(input bit with_start);
    i2.valid_ips = 1'b1;
    i2.start_core_img = with_start;
    tick();
    i2.valid_ips = 1'b0;
    i2.start_core_img = 1'b0;
    tick();
    tick();
    i2.stage_done = 2'b01;
    tick();
    i2.stage_done = 2'b00;
    tick();
    tick();
    i2.stage_done = 2'b10;
    tick();
    i2.stage_done = 2'b00;
  endtask

  task automatic test_reset;
    tick();
    tests++;
    if (i2.TU !== 16'd0 || i2.busy !== 1'b0 || i2.stage_idx !== 2'd0 || i2.stage_start !== 2'b00 ||
        i2.done_core_img !== 1'b0 || i2.aborted !== 1'b0 || i2.TU_incre !== 1'b0 || i2.timeout !== 1'b0) begin
      fails++;
      $display("FAIL reset: TU=%0d busy=%b idx=%0d ss=%b done=%b ab=%b inc=%b to=%b expected all 0",
               i2.TU, i2.busy, i2.stage_idx, i2.stage_start, i2.done_core_img, i2.aborted, i2.TU_incre, i2.timeout);
    end
    #1 rst = 1'b1;
    tick();
  endtask

  task automatic test_image;
    start2(3, 1'b1);
    tests++;
    if (i2.busy !== 1'b1) begin fails++; $display("FAIL image_busy: busy=%b expected 1", i2.busy); end
    for (int t = 0; t < 3; t++) begin
      tests++;
      if (i2.TU !== 16'(t)) begin fails++; $display("FAIL image_tu_pre: TU=%0d expected %0d", i2.TU, t); end
      step2(1'b0);
      tests++;
      if (i2.TU_incre !== 1'b1 || i2.TU !== 16'((t + 1) % 3) || i2.done_core_img !== (t == 2)) begin
        fails++;
        $display("FAIL image_step%0d: inc=%b TU=%0d done=%b expected 1 %0d %b",
                 t, i2.TU_incre, i2.TU, i2.done_core_img, (t + 1) % 3, t == 2);
      end
    end
    tests++;
    if (i2.busy !== 1'b0) begin fails++; $display("FAIL image_busy_fall: busy=%b expected 0", i2.busy); end
    tick();
    tests++;
    if (i2.done_core_img !== 1'b0 || i2.TU_incre !== 1'b0) begin
      fails++;
      $display("FAIL image_pulse_width: done=%b inc=%b expected 0 0", i2.done_core_img, i2.TU_incre);
    end
  endtask

  task automatic test_single_shot;
    start2(2, 1'b0);
    step2(1'b0);
    tests++;
    if (i2.TU !== 16'd1 || i2.done_core_img !== 1'b0) begin
      fails++;
      $display("FAIL ss_first: TU=%0d done=%b expected 1 0", i2.TU, i2.done_core_img);
    end
    i2.valid_ips = 1'b1;
    tick();
    i2.valid_ips = 1'b0;
    tests++;
    if (i2.stage_start !== 2'b00) begin fails++; $display("FAIL ss_gate: ss=%b expected 00", i2.stage_start); end
    step2(1'b1);
    tests++;
    if (i2.done_core_img !== 1'b1 || i2.TU !== 16'd0 || i2.busy !== 1'b0) begin
      fails++;
      $display("FAIL ss_done: done=%b TU=%0d busy=%b expected 1 0 0", i2.done_core_img, i2.TU, i2.busy);
    end
  endtask

  task automatic test_walk;
    logic [3:0] m;
    i4.num_timesteps = 16'd1;
    i4.cont_mode = 1'b1;
    i4.start_core_img = 1'b1;
    tick();
    i4.start_core_img = 1'b0;
    i4.stage_done = 4'b1111;
    tick();
    i4.stage_done = 4'b0000;
    tests++;
    if (i4.stage_start !== 4'b0000 || i4.TU_incre !== 1'b0) begin
      fails++;
      $display("FAIL walk_armed_done: ss=%b inc=%b expected 0000 0", i4.stage_start, i4.TU_incre);
    end
    i4.valid_ips = 1'b1;
    tick();
    i4.valid_ips = 1'b0;
    tests++;
    if (i4.stage_start !== 4'b0001 || i4.stage_idx !== 2'd0) begin
      fails++;
      $display("FAIL walk_s0: ss=%b idx=%0d expected 0001 0", i4.stage_start, i4.stage_idx);
    end
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        i4.stage_done = 4'b0100;
        tick();
        i4.stage_done = 4'b0000;
        tests++;
        if (i4.stage_start !== 4'b0000 || i4.stage_idx !== 2'd1) begin
          fails++;
          $display("FAIL walk_ignore: ss=%b idx=%0d expected 0000 1", i4.stage_start, i4.stage_idx);
        end
      end
      m = 4'(1 << k);
      i4.stage_done = m;
      tick();
      i4.stage_done = 4'b0000;
      m = 4'(2 << k);
      tests++;
      if (k < 3 && (i4.stage_start !== m || i4.stage_idx !== 2'(k + 1))) begin
        fails++;
        $display("FAIL walk_s%0d: ss=%b idx=%0d expected %b %0d", k + 1, i4.stage_start, i4.stage_idx, m, k + 1);
      end else if (k == 3 && (i4.stage_start !== 4'b0000 || i4.TU_incre !== 1'b1 || i4.done_core_img !== 1'b1)) begin
        fails++;
        $display("FAIL walk_end: ss=%b inc=%b done=%b expected 0000 1 1", i4.stage_start, i4.TU_incre, i4.done_core_img);
      end
    end
  endtask

  task automatic test_zero_limit;
    start2(0, 1'b1);
    i2.num_timesteps = 16'd2;
    i2.start_core_img = 1'b1;
    tick();
    i2.start_core_img = 1'b0;
    step2(1'b0);
    tests++;
    if (i2.done_core_img !== 1'b1 || i2.TU !== 16'd0 || i2.busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_limit: done=%b TU=%0d busy=%b expected 1 0 0", i2.done_core_img, i2.TU, i2.busy);
    end
  endtask

  task automatic test_abort;
    start2(10, 1'b1);
    for (int t = 0; t < 5; t++) step2(1'b0);
    tests++;
    if (i2.TU !== 16'd5) begin fails++; $display("FAIL abort_tu5: TU=%0d expected 5", i2.TU); end
    i2.valid_ips = 1'b1;
    tick();
    i2.valid_ips = 1'b0;
    i2.stage_done = 2'b01;
    tick();
    i2.stage_done = 2'b00;
    i2.abort = 1'b1;
    tick();
    i2.abort = 1'b0;
    tests++;
    if (i2.aborted !== 1'b1 || i2.TU !== 16'd0 || i2.busy !== 1'b0 || i2.done_core_img !== 1'b0 ||
        i2.TU_incre !== 1'b0 || i2.stage_idx !== 2'd0) begin
      fails++;
      $display("FAIL abort_mid: ab=%b TU=%0d busy=%b done=%b inc=%b idx=%0d expected 1 0 0 0 0 0",
               i2.aborted, i2.TU, i2.busy, i2.done_core_img, i2.TU_incre, i2.stage_idx);
    end
    i2.abort = 1'b1;
    tick();
    i2.abort = 1'b0;
    tests++;
    if (i2.aborted !== 1'b0) begin fails++; $display("FAIL abort_idle: ab=%b expected 0", i2.aborted); end
    start2(1, 1'b1);
    i2.valid_ips = 1'b1;
    tick();
    i2.valid_ips = 1'b0;
    i2.stage_done = 2'b01;
    tick();
    i2.stage_done = 2'b10;
    i2.abort = 1'b1;
    tick();
    i2.stage_done = 2'b00;
    i2.abort = 1'b0;
    tests++;
    if (i2.aborted !== 1'b1 || i2.done_core_img !== 1'b0 || i2.TU_incre !== 1'b0) begin
      fails++;
      $display("FAIL abort_vs_done: ab=%b done=%b inc=%b expected 1 0 0", i2.aborted, i2.done_core_img, i2.TU_incre);
    end
  endtask

  task automatic test_async_reset;
    start2(20, 1'b1);
    for (int t = 0; t < 7; t++) step2(1'b0);
    i2.valid_ips = 1'b1;
    tick();
    i2.valid_ips = 1'b0;
    i2.stage_done = 2'b01;
    tick();
    i2.stage_done = 2'b00;
    tests++;
    if (i2.TU !== 16'd7 || i2.stage_start !== 2'b10) begin
      fails++;
      $display("FAIL areset_pre: TU=%0d ss=%b expected 7 10", i2.TU, i2.stage_start);
    end
    #3 rst = 1'b0;
    #1;
    tests++;
    if (i2.TU !== 16'd0 || i2.busy !== 1'b0 || i2.stage_start !== 2'b00 || i2.stage_idx !== 2'd0) begin
      fails++;
      $display("FAIL areset_now: TU=%0d busy=%b ss=%b idx=%0d expected 0 0 00 0",
               i2.TU, i2.busy, i2.stage_start, i2.stage_idx);
    end
    #1 rst = 1'b1;
    tick();
    start2(2, 1'b1);
    tests++;
    if (i2.TU !== 16'd0 || i2.busy !== 1'b1) begin
      fails++;
      $display("FAIL areset_restart: TU=%0d busy=%b expected 0 1", i2.TU, i2.busy);
    end
    step2(1'b0);
    tests++;
    if (i2.TU !== 16'd1 || i2.done_core_img !== 1'b0) begin
      fails++;
      $display("FAIL areset_step: TU=%0d done=%b expected 1 0", i2.TU, i2.done_core_img);
    end
    i2.abort = 1'b1;
    tick();
    i2.abort = 1'b0;
  endtask

  task automatic test_timeout;
    start2(1, 1'b1);
    i2.valid_ips = 1'b1;
    tick();
    i2.valid_ips = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    for (int c = 0; c < 15; c++) tick();
    tests++;
    if (i2.timeout !== 1'b0 || i2.aborted !== 1'b0) begin
      fails++;
      $display("FAIL to_early: to=%b ab=%b expected 0 0", i2.timeout, i2.aborted);
    end
    tick();
    tests++;
    if (i2.timeout !== 1'b1 || i2.aborted !== 1'b1 || i2.busy !== 1'b0 || i2.TU !== 16'd0) begin
      fails++;
      $display("FAIL to_fire: to=%b ab=%b busy=%b TU=%0d expected 1 1 0 0", i2.timeout, i2.aborted, i2.busy, i2.TU);
    end
    start2(1, 1'b1);
    i2.valid_ips = 1'b1;
    tick();
    i2.valid_ips = 1'b0;
    for (int c = 0; c < 15; c++) tick();
    i2.stage_done = 2'b01;
    tick();
    i2.stage_done = 2'b00;
    tests++;
    if (i2.timeout !== 1'b0 || i2.aborted !== 1'b0 || i2.stage_start !== 2'b10) begin
      fails++;
      $display("FAIL to_race: to=%b ab=%b ss=%b expected 0 0 10", i2.timeout, i2.aborted, i2.stage_start);
    end
    i2.stage_done = 2'b10;
    tick();
    i2.stage_done = 2'b00;
    tests++;
    if (i2.done_core_img !== 1'b1) begin fails++; $display("FAIL to_finish: done=%b expected 1", i2.done_core_img); end
`else
    for (int c = 0; c < 20; c++) tick();
    tests++;
    if (i2.timeout !== 1'b0 || i2.aborted !== 1'b0 || i2.busy !== 1'b1) begin
      fails++;
      $display("FAIL to_off: to=%b ab=%b busy=%b expected 0 0 1", i2.timeout, i2.aborted, i2.busy);
    end
    i2.abort = 1'b1;
    tick();
    i2.abort = 1'b0;
`endif
  endtask

  initial begin
    {i2.valid_ips, i2.start_core_img, i2.cont_mode, i2.abort} = '0;
    {i4.valid_ips, i4.start_core_img, i4.cont_mode, i4.abort} = '0;
    i2.num_timesteps = '0;
    i4.num_timesteps = '0;
    i2.stage_done = '0;
    i4.stage_done = '0;
    test_reset();
    test_image();
    test_single_shot();
    test_walk();
    test_zero_limit();
    test_abort();
    test_async_reset();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
